regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file, successor to the 2R/1W core register file. It provides configurable data width, depth, and read/write port counts. Other features:
- same-cycle write-to-read bypass;
- deterministic write-port priority;
- an optional hardwired zero register;
- a hardware clear sweep after reset, so a deep array needs no reset fan-out.

It sits between decode (read ports), writeback (write ports) and the debug tap (debug read port).

---
 rtl/regfile_mp.sv | 112 +++++++++++
 tb/tb_regfile_mp.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: zero-latency reads with same-cycle
// write bypass, highest-port-wins writes, optional zero register and a clear sweep.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic                     clr_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_run;
  logic              w_sweep_last;

  assign w_sweep_last = (r_cnt == ADDR_LAST);
  assign w_run        = !rst && (r_state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_CLEAR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: begin
        if (w_sweep_last) w_state_nxt = ST_RUN;
        else              w_state_nxt = ST_CLEAR;
      end
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  always_comb begin
    if (rst)                        clr_busy = 1'b1;
    else if (r_state == ST_CLEAR)   clr_busy = 1'b1;
    else                            clr_busy = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)                        r_cnt <= ADDR_ZERO;
    else if (r_state == ST_CLEAR)   r_cnt <= r_cnt + ADDR_ONE;
    else                            r_cnt <= r_cnt;
  end

  // Array has no reset; the sweep zeroes one entry per cycle. Later ports override earlier ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_cnt] <= DATA_ZERO;
      end else begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (we[i] && !((ZERO_REG != 0) && (waddr[i*ADDR_W +: ADDR_W] == ADDR_ZERO)))
            r_mem[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;

    assign w_ra = raddr[j*ADDR_W +: ADDR_W];

    always_comb begin
      w_rd = DATA_ZERO;
      if (!w_run || !re[j]) begin
        w_rd = DATA_ZERO;
      end else if ((ZERO_REG != 0) && (w_ra == ADDR_ZERO)) begin
        w_rd = DATA_ZERO;
      end else begin
        w_rd = r_mem[w_ra];
        for (int i = 0; i < NUM_WR; i++)
          w_rd = (we[i] && (waddr[i*ADDR_W +: ADDR_W] == w_ra)) ? wdata[i*DATA_W +: DATA_W] : w_rd;
      end
    end

    assign rdata[j*DATA_W +: DATA_W] = w_rd;
  end

  always_comb begin
    if (!w_run)                                             dbg_data = DATA_ZERO;
    else if ((ZERO_REG != 0) && (dbg_addr == ADDR_ZERO))    dbg_data = DATA_ZERO;
    else                                                    dbg_data = r_mem[dbg_addr];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: three instances (defaults, ZERO_REG=0, and a
// 4-read/1-write 64-entry variant) checked against an array model every cycle.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // shared stimulus for instances A (ZERO_REG=1) and B (ZERO_REG=0)
  logic [1:0]   we;
  logic [9:0]   waddr;
  logic [63:0]  wdata;
  logic [1:0]   re;
  logic [9:0]   raddr;
  logic [4:0]   dbg_addr;
  logic [63:0]  rdata_a, rdata_b;
  logic [31:0]  dbg_a, dbg_b;
  logic         busy_a, busy_b;

  // instance C: NUM_RD=4, NUM_WR=1, ADDR_W=6
  logic         c_we;
  logic [5:0]   c_waddr;
  logic [31:0]  c_wdata;
  logic [3:0]   c_re;
  logic [23:0]  c_raddr;
  logic [5:0]   c_dbg_addr;
  logic [127:0] rdata_c;
  logic [31:0]  dbg_c;
  logic         busy_c;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) u_a (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
    .rdata(rdata_a), .dbg_addr(dbg_addr), .dbg_data(dbg_a), .clr_busy(busy_a));

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
    .rdata(rdata_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b), .clr_busy(busy_b));

  regfile_mp #(.DATA_W(32), .ADDR_W(6), .NUM_RD(4), .NUM_WR(1), .ZERO_REG(1)) u_c (
    .clk(clk), .rst(rst), .we(c_we), .waddr(c_waddr), .wdata(c_wdata), .re(c_re), .raddr(c_raddr),
    .rdata(rdata_c), .dbg_addr(c_dbg_addr), .dbg_data(dbg_c), .clr_busy(busy_c));

  // ---------------- scoreboard ----------------
  typedef struct {
    int          inst;   // 0=A 1=B 2=C
    int          kind;   // 0=rdata 1=dbg_data 2=clr_busy
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic push(input int inst, input int kind, input int port, input logic [31:0] v);
    exp_t e;
    e.inst = inst; e.kind = kind; e.port = port; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_now(input string what, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h at %0t", what, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] actual(input int inst, input int kind, input int port);
    logic [31:0] v;
    v = 32'h0;
    if (inst == 0) begin
      if (kind == 0)      v = rdata_a[port*32 +: 32];
      else if (kind == 1) v = dbg_a;
      else                v = {31'h0, busy_a};
    end else if (inst == 1) begin
      if (kind == 0)      v = rdata_b[port*32 +: 32];
      else if (kind == 1) v = dbg_b;
      else                v = {31'h0, busy_b};
    end else begin
      if (kind == 0)      v = rdata_c[port*32 +: 32];
      else if (kind == 1) v = dbg_c;
      else                v = {31'h0, busy_c};
    end
    return v;
  endfunction

  function automatic string kname(input int kind);
    if (kind == 0) return "rdata";
    if (kind == 1) return "dbg_data";
    return "clr_busy";
  endfunction

  // monitor: outputs are settled at the falling edge; drain everything queued this cycle
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = actual(e.inst, e.kind, e.port);
      n_vec++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s inst=%0d port=%0d got=%h expected=%h at %0t",
                 kname(e.kind), e.inst, e.port, act, e.exp, $time);
      end
    end
  end

  // ---------------- reference model ----------------
  // Reset empties the file (the sweep guarantees zeros on entry to RUN); the file is
  // busy for DEPTH edges after reset release and ignores writes meanwhile.
  logic [31:0] m_a [32];
  logic [31:0] m_b [32];
  logic [31:0] m_c [64];
  int          since = 0;   // edges with rst=0 since the last reset edge

  function automatic logic [31:0] exp_rd_ab(input bit zero, input int j);
    logic [4:0]  a;
    logic [31:0] v;
    if (rst || since < 32 || !re[j]) return 32'h0;
    a = raddr[j*5 +: 5];
    if (zero && a == 5'd0) return 32'h0;
    v = zero ? m_a[a] : m_b[a];
    for (int i = 0; i < 2; i++)
      if (we[i] && waddr[i*5 +: 5] == a) v = wdata[i*32 +: 32];
    return v;
  endfunction

  function automatic logic [31:0] exp_dbg_ab(input bit zero);
    if (rst || since < 32) return 32'h0;
    if (zero && dbg_addr == 5'd0) return 32'h0;
    return zero ? m_a[dbg_addr] : m_b[dbg_addr];
  endfunction

  function automatic logic [31:0] exp_rd_c(input int j);
    logic [5:0] a;
    if (rst || since < 64 || !c_re[j]) return 32'h0;
    a = c_raddr[j*6 +: 6];
    if (a == 6'd0) return 32'h0;
    if (c_we && c_waddr == a) return c_wdata;
    return m_c[a];
  endfunction

  function automatic logic [31:0] exp_dbg_c();
    if (rst || since < 64 || c_dbg_addr == 6'd0) return 32'h0;
    return m_c[c_dbg_addr];
  endfunction

  task automatic push_model();
    for (int j = 0; j < 2; j++) begin
      push(0, 0, j, exp_rd_ab(1'b1, j));
      push(1, 0, j, exp_rd_ab(1'b0, j));
    end
    push(0, 1, 0, exp_dbg_ab(1'b1));
    push(1, 1, 0, exp_dbg_ab(1'b0));
    push(0, 2, 0, {31'h0, (rst || since < 32)});
    push(1, 2, 0, {31'h0, (rst || since < 32)});
    for (int j = 0; j < 4; j++) push(2, 0, j, exp_rd_c(j));
    push(2, 1, 0, exp_dbg_c());
    push(2, 2, 0, {31'h0, (rst || since < 64)});
  endtask

  task automatic model_edge();
    logic [4:0] a;
    if (rst) begin
      since = 0;
      foreach (m_a[k]) begin m_a[k] = 32'h0; m_b[k] = 32'h0; end
      foreach (m_c[k]) m_c[k] = 32'h0;
    end else begin
      if (since >= 32) begin
        for (int i = 0; i < 2; i++) begin
          if (we[i]) begin
            a = waddr[i*5 +: 5];
            if (a != 5'd0) m_a[a] = wdata[i*32 +: 32];
            m_b[a] = wdata[i*32 +: 32];
          end
        end
      end
      if (since >= 64 && c_we && c_waddr != 6'd0) m_c[c_waddr] = c_wdata;
      if (since < 1000) since++;
    end
  endtask

  // ---------------- driver ----------------
  task automatic apply();
    push_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clr_in();
    we = 2'b00; waddr = 10'h0; wdata = 64'h0; re = 2'b00; raddr = 10'h0; dbg_addr = 5'd0;
    c_we = 1'b0; c_waddr = 6'd0; c_wdata = 32'h0; c_re = 4'h0; c_raddr = 24'h0; c_dbg_addr = 6'd0;
  endtask

  task automatic wait_sweep();
    int guard;
    rst = 1'b0;
    clr_in();
    guard = 0;
    while (since < 64 && guard < 200) begin
      apply();
      guard++;
    end
    check_now("sweep wait expired", 128'(since >= 64), 128'h1);
    check_now("clr_busy after sweep wait", {125'h0, busy_a, busy_b, busy_c}, 128'h0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    apply();
    rst = 1'b0;
  endtask

  initial begin
    clr_in();
    rst = 1'b1;
    #1;

    // 1: reset 3 cycles, sweep length, reads after the sweep
    for (int k = 0; k < 3; k++) apply();
    re = 2'b11; raddr = {5'd31, 5'd5}; dbg_addr = 5'd17;
    c_re = 4'hF; c_raddr = {6'd63, 6'd17, 6'd5, 6'd1}; c_dbg_addr = 6'd17;
    #1;
    check_now("reset-state clr_busy", {125'h0, busy_a, busy_b, busy_c}, 128'h7);
    check_now("reset-state rdata_a/b", {rdata_a, rdata_b}, 128'h0);
    check_now("reset-state rdata_c", rdata_c, 128'h0);
    check_now("reset-state dbg_data", {32'h0, dbg_a, dbg_b, dbg_c}, 128'h0);
    c_re = 4'h0; c_raddr = 24'h0; c_dbg_addr = 6'd0;
    rst = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      push(0, 2, 0, (k < 32) ? 32'h1 : 32'h0);
      apply();
    end
    push(0, 0, 0, 32'h0); push(0, 0, 1, 32'h0); push(0, 1, 0, 32'h0);
    apply();

    // 2: write then read, bypass, debug sees old value first
    clr_in();
    we = 2'b01; waddr[4:0] = 5'd3; wdata[31:0] = 32'hDEADBEEF;
    apply();
    clr_in();
    re = 2'b01; raddr[4:0] = 5'd3;
    push(0, 0, 0, 32'hDEADBEEF);
    apply();
    we = 2'b01; waddr[4:0] = 5'd7; wdata[31:0] = 32'h12345678;
    raddr[4:0] = 5'd7; dbg_addr = 5'd7;
    push(0, 0, 0, 32'h12345678); push(0, 1, 0, 32'h0);
    apply();
    we = 2'b00;
    push(0, 1, 0, 32'h12345678);
    apply();

    // 3: write priority, higher port wins
    clr_in();
    we = 2'b11; waddr = {5'd9, 5'd9}; wdata = {32'h5555FFFF, 32'hAAAA0000};
    re = 2'b01; raddr[4:0] = 5'd9;
    push(0, 0, 0, 32'h5555FFFF);
    apply();
    we = 2'b00;
    push(0, 0, 0, 32'h5555FFFF); push(1, 0, 0, 32'h5555FFFF);
    apply();

    // 4: zero register vs. ordinary entry 0
    clr_in();
    we = 2'b01; waddr[4:0] = 5'd0; wdata[31:0] = 32'hFFFFFFFF;
    re = 2'b11; raddr = 10'h0; dbg_addr = 5'd0;
    push(0, 0, 0, 32'h0); push(0, 1, 0, 32'h0); push(1, 0, 0, 32'hFFFFFFFF);
    apply();
    we = 2'b00;
    push(0, 0, 0, 32'h0); push(0, 1, 0, 32'h0);
    push(1, 0, 0, 32'hFFFFFFFF); push(1, 1, 0, 32'hFFFFFFFF);
    apply();

    // 5: writes during the sweep are ignored
    clr_in();
    pulse_rst();
    for (int k = 0; k < 4; k++) apply();
    we = 2'b01; waddr[4:0] = 5'd2; wdata[31:0] = 32'h11111111;
    re = 2'b01; raddr[4:0] = 5'd2;
    push(0, 0, 0, 32'h0); push(0, 2, 0, 32'h1);
    apply();
    wait_sweep();
    re = 2'b01; raddr[4:0] = 5'd2;
    push(0, 0, 0, 32'h0); push(1, 0, 0, 32'h0);
    apply();

    // 6: reset mid-sweep restarts it; reset clears populated entries
    clr_in();
    pulse_rst();
    for (int k = 0; k < 10; k++) apply();
    pulse_rst();
    for (int k = 0; k <= 64; k++) begin
      push(0, 2, 0, (k < 32) ? 32'h1 : 32'h0);
      push(2, 2, 0, (k < 64) ? 32'h1 : 32'h0);
      apply();
    end
    we = 2'b01; waddr[4:0] = 5'd20; wdata[31:0] = 32'hCAFEF00D;
    apply();
    clr_in();
    re = 2'b01; raddr[4:0] = 5'd20;
    push(0, 0, 0, 32'hCAFEF00D);
    apply();
    pulse_rst();
    wait_sweep();
    re = 2'b01; raddr[4:0] = 5'd20;
    push(0, 0, 0, 32'h0);
    apply();

    // variant C: write/read, bypass, debug, top entry
    clr_in();
    c_we = 1'b1; c_waddr = 6'd3; c_wdata = 32'hDEADBEEF;
    apply();
    clr_in();
    c_re = 4'b1000; c_raddr[23:18] = 6'd3;
    push(2, 0, 3, 32'hDEADBEEF);
    apply();
    c_we = 1'b1; c_waddr = 6'd7; c_wdata = 32'h12345678;
    c_re = 4'b0100; c_raddr[17:12] = 6'd7; c_dbg_addr = 6'd7;
    push(2, 0, 2, 32'h12345678); push(2, 1, 0, 32'h0);
    apply();
    c_we = 1'b1; c_waddr = 6'd63; c_wdata = 32'hA5A5C3C3;
    push(2, 1, 0, 32'h12345678);
    apply();
    clr_in();
    c_re = 4'b0001; c_raddr[5:0] = 6'd63;
    push(2, 0, 0, 32'hA5A5C3C3);
    apply();

    // random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      we = 2'($urandom);
      re = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        waddr[i*5 +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
        raddr[i*5 +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
        wdata[i*32 +: 32] = $urandom;
      end
      dbg_addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      c_we = 1'($urandom);
      c_waddr = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom);
      c_wdata = $urandom;
      c_re = 4'($urandom);
      for (int j = 0; j < 4; j++)
        c_raddr[j*6 +: 6] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom);
      c_dbg_addr = 6'($urandom);
      apply();
    end

    rst = 1'b0;
    clr_in();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    if (n_err == 0) $display("PASS");
    else            $display("FAIL: %0d miscompares", n_err);
    $finish;
  end

endmodule
